// File: rtl/testwave_pkg.sv
// Shared types for the multi-shape test waveform generator.
// Mode codes and triangle direction encoding.
package testwave_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP_UP = 2'd0,
    MODE_RAMP_DN = 2'd1,
    MODE_TRI     = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/testwave_phase_ctr.sv
// Phase/direction sequencer for the test waveform generator.
// Tracks the point to emit next and flags the first/last point of a period.
module testwave_phase_ctr
  import testwave_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk_20k,
  input  logic             rst_n,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] peak,
  output logic [WIDTH-1:0] phase,
  output dir_t             dir,
  output logic             first,
  output logic             last
);

  logic [WIDTH-1:0] p_q;
  dir_t             dir_q;
  logic             first_q;
  logic             peak_le1;
  logic             at_peak;

  assign phase    = p_q;
  assign dir      = dir_q;
  assign first    = first_q;
  assign peak_le1 = (peak[WIDTH-1:1] == '0);
  assign at_peak  = (p_q == peak);

  // Triangle holds the emitted value in p_q in both directions.
  always_comb begin
    last = at_peak;
    unique case (mode)
      MODE_TRI: begin
        if (dir_q == DIR_UP) begin
          last = at_peak && peak_le1;
        end else begin
          last = (p_q[WIDTH-1:1] == '0);
        end
      end
      default: last = at_peak;
    endcase
  end

  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      dir_q   <= DIR_UP;
      first_q <= 1'b1;
    end else if (en) begin
      if (last) begin
        p_q     <= '0;
        dir_q   <= DIR_UP;
        first_q <= 1'b1;
      end else begin
        first_q <= 1'b0;
        if (mode == MODE_TRI && dir_q == DIR_UP && at_peak) begin
          dir_q <= DIR_DN;
          p_q   <= peak - WIDTH'(1);
        end else if (mode == MODE_TRI && dir_q == DIR_DN) begin
          p_q <= p_q - WIDTH'(1);
        end else begin
          p_q <= p_q + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/testwave_gen_multi.sv
// Multi-shape test waveform source: ramp up/down, triangle, square.
// Config is latched only at period starts so periods are never mixed.
module testwave_gen_multi
  import testwave_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEF_MAX  = 639,
  parameter int DEF_MODE = 0
) (
  input  logic             clk_20k,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] max_in,
  output logic [WIDTH-1:0] sample,
  output logic             period_start,
  output logic             valid
);

  localparam logic [1:0] DefModeBits = DEF_MODE[1:0];

  mode_t            mode_q;
  logic [WIDTH-1:0] peak_q;
  logic             use_def_q;

  mode_t            mode_eff;
  logic [WIDTH-1:0] peak_eff;
  logic [WIDTH:0]   half;
  logic [WIDTH-1:0] phase;
  dir_t             dir;
  logic             first;
  logic             last;
  logic [WIDTH-1:0] nxt;
  logic             take_in;

  // The first period after reset runs on the reset defaults.
  assign take_in  = first && !use_def_q;
  assign mode_eff = take_in ? mode_t'(mode_in) : mode_q;
  assign peak_eff = take_in ? max_in : peak_q;
  assign half     = ({1'b0, peak_eff} + (WIDTH+1)'(1)) >> 1;

  testwave_phase_ctr #(
    .WIDTH (WIDTH)
  ) u_phase (
    .clk_20k (clk_20k),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode_eff),
    .peak    (peak_eff),
    .phase   (phase),
    .dir     (dir),
    .first   (first),
    .last    (last)
  );

  always_comb begin
    nxt = phase;
    unique case (mode_eff)
      MODE_RAMP_UP: nxt = phase;
      MODE_RAMP_DN: nxt = peak_eff - phase;
      MODE_TRI:     nxt = phase;
      MODE_SQUARE:  nxt = ({1'b0, phase} < half) ? '0 : peak_eff;
    endcase
  end

  always_ff @(posedge clk_20k or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      period_start <= 1'b0;
      valid        <= 1'b0;
      mode_q       <= mode_t'(DefModeBits);
      peak_q       <= WIDTH'(DEF_MAX);
      use_def_q    <= 1'b1;
    end else if (en) begin
      sample       <= nxt;
      period_start <= first;
      valid        <= 1'b1;
      if (first) begin
        mode_q    <= mode_eff;
        peak_q    <= peak_eff;
        use_def_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_testwave_gen_multi.sv
// Directed bench for testwave_gen_multi.
// Hand-computed sequences per shape, config switching, freeze and reset.
module tb_testwave_gen_multi;

  logic       clk_20k = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode_in;
  logic [9:0] max_in;
  logic [9:0] sample;
  logic       period_start;
  logic       valid;

  int total = 0;
  int fails = 0;

  testwave_gen_multi #(
    .WIDTH    (10),
    .DEF_MAX  (639),
    .DEF_MODE (0)
  ) dut (
    .clk_20k      (clk_20k),
    .rst_n        (rst_n),
    .en           (en),
    .mode_in      (mode_in),
    .max_in       (max_in),
    .sample       (sample),
    .period_start (period_start),
    .valid        (valid)
  );

  always #5 clk_20k = ~clk_20k;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_20k);
    #1;
  endtask

  task automatic pt(input string tag, input int s, input int ps);
    step();
    chk(tag, int'(sample), s);
    chk({tag, "_ps"}, int'(period_start), ps);
  endtask

  initial begin
    int tri4[8];
    tri4 = '{0, 1, 2, 3, 4, 3, 2, 1};
    rst_n   = 1'b0;
    en      = 1'b1;
    mode_in = 2'd0;
    max_in  = 10'd639;
    #2;
    chk("rst_sample", int'(sample), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_valid", int'(valid), 0);
    @(negedge clk_20k);
    rst_n = 1'b1;

    // full default ramp, valid rises on the first edge
    for (int i = 0; i < 640; i++) begin
      pt("ramp639", i, (i == 0) ? 1 : 0);
      if (i == 0) chk("valid_rise", int'(valid), 1);
    end

    mode_in = 2'd2;
    max_in  = 10'd4;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++)
        pt("tri4", tri4[i], (i == 0) ? 1 : 0);

    mode_in = 2'd3;
    max_in  = 10'd5;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 6; i++)
        pt("sq5", (i < 3) ? 0 : 5, (i == 0) ? 1 : 0);

    mode_in = 2'd3;
    max_in  = 10'd4;
    for (int i = 0; i < 5; i++)
      pt("sq4", (i < 2) ? 0 : 4, (i == 0) ? 1 : 0);

    // mid-period config change is deferred to next period
    mode_in = 2'd0;
    max_in  = 10'd9;
    for (int i = 0; i < 6; i++)
      pt("ru9", i, (i == 0) ? 1 : 0);
    mode_in = 2'd1;
    max_in  = 10'd3;
    for (int i = 6; i < 10; i++)
      pt("ru9_tail", i, 0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        pt("rd3", 3 - i, (i == 0) ? 1 : 0);

    mode_in = 2'd2;
    max_in  = 10'd4;
    pt("tri_pre", 0, 1);
    pt("tri_pre", 1, 0);
    pt("tri_pre", 2, 0);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("freeze_sample", int'(sample), 2);
      chk("freeze_ps", int'(period_start), 0);
    end
    en = 1'b1;
    pt("tri_post", 3, 0);
    pt("tri_post", 4, 0);
    pt("tri_post", 3, 0);
    pt("tri_post", 2, 0);
    pt("tri_post", 1, 0);

    max_in = 10'd0;
    for (int i = 0; i < 4; i++)
      pt("m0", 0, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_ps_hi", int'(period_start), 1);
      chk("freeze_valid", int'(valid), 1);
    end
    en = 1'b1;

    max_in = 10'd1;
    for (int k = 0; k < 2; k++) begin
      pt("tri1", 0, 1);
      pt("tri1", 1, 0);
    end

    mode_in = 2'd0;
    max_in  = 10'd9;
    for (int i = 0; i < 5; i++)
      pt("ru9b", i, (i == 0) ? 1 : 0);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sample", int'(sample), 0);
    chk("arst_ps", int'(period_start), 0);
    chk("arst_valid", int'(valid), 0);
    mode_in = 2'd2;
    max_in  = 10'd4;
    @(negedge clk_20k);
    rst_n = 1'b1;
    #1;
    chk("rel_valid", int'(valid), 0);
    for (int i = 0; i < 640; i++)
      pt("rst_def", i, (i == 0) ? 1 : 0);
    for (int i = 0; i < 6; i++)
      pt("rst_relatch", tri4[i], (i == 0) ? 1 : 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/testwave_gen_multi.md
Name: testwave_gen_multi

Overview:
Parametrised successor to the single-ramp test source. Generates one of four test waveforms (ramp up, ramp down, triangle, square) at a runtime-selectable peak, one sample per enabled clk_20k edge. Feeds the scope/display path in place of microphone samples during bring-up and self-test. Adds enable/freeze, a period-start marker and glitch-free config changes at period boundaries.

Parameters:
WIDTH, 10, sample and peak width in bits
DEF_MAX, 639, peak value loaded at reset, before the first period latches max_in
DEF_MODE, 0, mode loaded at reset (0 = ramp up)

Ports:
clk_20k  in  1  sample clock, 20 kHz
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = advance one point per edge; 0 = freeze all state and outputs
mode_in  in  2  0 ramp up, 1 ramp down, 2 triangle, 3 square
max_in  in  WIDTH  requested peak M
sample  out  WIDTH  registered waveform sample
period_start  out  1  high for exactly the cycle sample holds the period's first point
valid  out  1  0 after reset until the first enabled edge, then 1

Behaviour:
- Reset (asynchronous, rst_n=0): sample=0, period_start=0, valid=0, phase=0, dir=up, active mode=DEF_MODE, active M=DEF_MAX, next point = first point. Outputs go to these values immediately, without waiting for a clock edge.
- Latency: sample is registered. The point computed at an enabled edge appears right after that edge. The first enabled edge after reset emits the first point and sets valid=1, period_start=1.
- Config latch: mode_in and max_in are sampled only on the edge that emits a period's first point, and the latched values are used for the whole period. Changes mid-period take effect from the next period. No partial or mixed periods.
- en=0: phase, dir, sample, period_start and valid all hold. period_start stays 1 if it was 1.
- Shapes, with M = latched peak and phase p counting 0..M unless noted:
  - RAMP_UP: sample=p. Period M+1. Wraps M->0.
  - RAMP_DN: sample=M-p. Period M+1.
  - TRI: two-state dir FSM.
    - UP: emits 0..M; at M switch to DOWN.
    - DOWN: emits M-1..1; after 1, switch to UP and start a new period at 0.
    - Period 2M for M>=2.
    - M=1: sequence 0,1,0,1..., period 2.
  - SQUARE: sample=0 while p < H, else M, where H=(M+1)>>1. Period M+1.
- M=0, any mode: sample=0 every cycle, period_start=1 every enabled cycle.
- Arithmetic: unsigned WIDTH bits. p never exceeds M, so there is no overflow. H is computed in WIDTH+1 bits.
- rst_n asserted mid-period: abandons the period at once. The next enabled edge after release emits the first point of DEF_MODE/DEF_MAX. Config is re-latched from mode_in/max_in only at the following period start.
- period_start is 0 on every non-first point.

Decomposition:
- Package testwave_pkg:
  - mode codes MODE_RAMP_UP=2'd0, MODE_RAMP_DN=2'd1, MODE_TRI=2'd2, MODE_SQUARE=2'd3
  - triangle dir encoding DIR_UP/DIR_DN
- Sub-module testwave_phase_ctr: holds phase, dir and the first-point flag, and produces first/last-point strobes. It is parametrised by WIDTH.
- Top holds the config shadow registers, the shape mapping and the output registers.

Test Plan:
1. Reset, mode_in=0, max_in=639, en=1 -> sample 0,1,...,639,0; period_start high on both 0s; valid rises on the first edge.
2. mode_in=2, max_in=4 -> 0,1,2,3,4,3,2,1,0,...; period 8; period_start only on 0.
3. mode_in=3, max_in=5 (H=3) -> 0,0,0,5,5,5 repeating; mode_in=3, max_in=4 (H=2) -> 0,0,4,4,4.
4. In ramp up with max_in=9, switch to mode_in=1, max_in=3 at p=5 -> ramp continues 6..9, then 3,2,1,0 repeating.
5. Toggle en low for 7 cycles mid-triangle -> sample/period_start frozen; resumes at the exact next point. Also max_in=0 -> constant 0 with period_start every cycle.
6. Assert rst_n low between edges mid-period -> outputs 0 immediately, asynchronously. After release, the sequence restarts at 0 with DEF_MODE/DEF_MAX.
